// File: rtl/mini_pkg.sv
// mini_pkg: state encoding and elaboration helpers shared by the MINI datapath blocks.
// Rev 1.0
`default_nettype none

package mini_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Ceiling log2; callers clamp to a 1-bit minimum themselves.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/digit_adder.sv
// digit_adder: combinational W-bit ripple-carry adder built from FullAdder cells.
// Rev 1.0
`default_nettype none

module digit_adder #(
   parameter int W = 4
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         CIN,
   output logic [W-1:0] SUM,
   output logic         CARRY
);

   logic [W:0] w_c;

   assign w_c[0] = CIN;

   for (genvar i = 0; i < W; i++) begin : g_fa
      FullAdder u_fa (
         .a    (A[i]),
         .b    (B[i]),
         .cin  (w_c[i]),
         .sum  (SUM[i]),
         .cout (w_c[i+1])
      );
   end

   assign CARRY = w_c[W];

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// FullAdder: 1-bit full adder cell.
// Rev 1.0
`default_nettype none

module FullAdder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor, DIGIT bits per clock with start/busy/done handshake.
// Rev 1.0
`default_nettype none

module serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   input  logic             SUB,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             CARRY,
   output logic             OVERFLOW
);

   import mini_pkg::*;

   localparam int            N    = WIDTH / DIGIT;
   localparam int            CW   = (N > 1) ? clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_adder: DIGIT must divide WIDTH exactly");
   end

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT-1:0] w_digit_sum;
   logic             w_digit_carry;
   logic [WIDTH-1:0] w_res_next;
   logic             w_ovf;

   digit_adder #(
      .W (DIGIT)
   ) u_digit (
      .A     (a_sh_q[DIGIT-1:0]),
      .B     (b_sh_q[DIGIT-1:0]),
      .CIN   (carry_q),
      .SUM   (w_digit_sum),
      .CARRY (w_digit_carry)
   );

   // New digit enters at the top; after N steps the result is LSB-aligned.
   assign w_res_next = (res_q >> DIGIT) | (WIDTH'(w_digit_sum) << (WIDTH - DIGIT));

   // On the last digit the low bits of the shift registers hold the operand MSBs.
   assign w_ovf = (a_sh_q[DIGIT-1] == b_sh_q[DIGIT-1]) &&
                  (w_digit_sum[DIGIT-1] != a_sh_q[DIGIT-1]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      carry_d = carry_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               a_sh_d  = A;
               b_sh_d  = SUB ? ~B : B;
               carry_d = SUB ? 1'b1 : CIN;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sh_d  = a_sh_q >> DIGIT;
            b_sh_d  = b_sh_q >> DIGIT;
            res_d   = w_res_next;
            carry_d = w_digit_carry;
            if (cnt_q == LAST) begin
               sum_d   = w_res_next;
               cout_d  = w_digit_carry;
               ovf_d   = w_ovf;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign SUM      = sum_q;
   assign CARRY    = cout_q;
   assign OVERFLOW = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed bench with an arithmetic reference model for serial_adder.
// Rev 1.0
`default_nettype none

module tb_serial_adder;

   localparam int N16 = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] a, b;
   logic        cin, sub;
   logic        busy, done, carry, ovf;
   logic [15:0] sum;

   logic       start8;
   logic [7:0] a8, b8;
   logic       busy1, done1, c1, v1;
   logic [7:0] sum1;
   logic       busy8, done8, c8, v8;
   logic [7:0] sum8;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
      .CLK(clk), .RST_N(rst_n), .START(start), .A(a), .B(b), .CIN(cin), .SUB(sub),
      .BUSY(busy), .DONE(done), .SUM(sum), .CARRY(carry), .OVERFLOW(ovf)
   );

   serial_adder #(.WIDTH(8), .DIGIT(1)) dut_8x1 (
      .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8), .CIN(1'b0), .SUB(1'b0),
      .BUSY(busy1), .DONE(done1), .SUM(sum1), .CARRY(c1), .OVERFLOW(v1)
   );

   serial_adder #(.WIDTH(8), .DIGIT(8)) dut_8x8 (
      .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8), .CIN(1'b0), .SUB(1'b0),
      .BUSY(busy8), .DONE(done8), .SUM(sum8), .CARRY(c8), .OVERFLOW(v8)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: {overflow, carry, sum} from plain integer arithmetic.
   function automatic logic [17:0] model_op(input int w, input longint x, input longint y,
                                            input bit ci, input bit sb);
      longint mask, half, ye, c, u, sx, sy, s;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ye   = sb ? (~y & mask) : (y & mask);
      c    = sb ? 1 : longint'(ci);
      u    = (x & mask) + ye + c;
      sx   = ((x & half) != 0) ? (x & mask) - (half << 1) : (x & mask);
      sy   = ((ye & half) != 0) ? ye - (half << 1) : ye;
      s    = sx + sy + c;
      return {(s >= half || s < -half), (((u >> w) & 1) != 0), 16'(u & mask)};
   endfunction

   bit          model_on = 0;
   int          rem = 0;
   logic [17:0] pend = '0;
   logic        exp_busy = 0, exp_done = 0, exp_c = 0, exp_v = 0;
   logic [15:0] exp_sum = '0;

   initial begin
      forever begin
         @(posedge clk);
         model_on = 1;
         if (!rst_n) begin
            rem = 0; exp_busy = 0; exp_done = 0; exp_sum = '0; exp_c = 0; exp_v = 0;
         end else begin
            exp_done = 0;
            if (rem == 0) begin
               if (start) begin
                  pend = model_op(16, longint'(a), longint'(b), cin, sub);
                  rem  = N16;
               end
            end else begin
               rem--;
               if (rem == 0) begin
                  exp_sum  = pend[15:0];
                  exp_c    = pend[16];
                  exp_v    = pend[17];
                  exp_done = 1;
               end
            end
            exp_busy = (rem != 0);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (model_on) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("sum", 32'(sum), 32'(exp_sum));
            check("carry", 32'(carry), 32'(exp_c));
            check("overflow", 32'(ovf), 32'(exp_v));
         end
      end
   end

   // Called on a negedge; START is accepted at the following posedge.
   task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                         input logic xs, input int glitch_cyc, input int rst_cyc,
                         output int lat, output int busy_cnt, output bit saw_done);
      logic [15:0] hold;
      int cyc;
      hold = sum;
      a = xa; b = xb; cin = xc; sub = xs; start = 1;
      @(negedge clk);
      start = 0; cyc = 0; lat = -1; busy_cnt = 0; saw_done = 0;
      while (cyc <= 12) begin
         if (done) begin
            saw_done = 1;
            lat = cyc;
            break;
         end
         if (busy) begin
            busy_cnt++;
            check("sum_hold", 32'(sum), 32'(hold));
         end
         if (cyc == glitch_cyc) begin
            start = 1; a = 16'hAAAA; b = 16'h5555; sub = 1;
         end else begin
            start = 0;
         end
         rst_n = (cyc == rst_cyc) ? 1'b0 : 1'b1;
         @(negedge clk);
         cyc++;
      end
      start = 0;
      rst_n = 1;
   endtask

   task automatic expect_op(input string nm, input logic [15:0] xa, input logic [15:0] xb,
                            input logic xc, input logic xs, input int glitch_cyc,
                            input logic [15:0] es, input logic ec, input logic ev);
      int lat, bc;
      bit sd;
      run_op(xa, xb, xc, xs, glitch_cyc, -1, lat, bc, sd);
      check({nm, "_done_seen"}, 32'(sd), 32'd1);
      check({nm, "_latency"}, 32'(lat), 32'd4);
      check({nm, "_busy_cycles"}, 32'(bc), 32'd4);
      check({nm, "_sum"}, 32'(sum), 32'(es));
      check({nm, "_carry"}, 32'(carry), 32'(ec));
      check({nm, "_ovf"}, 32'(ovf), 32'(ev));
   endtask

   initial begin
      int lat, bc, cyc, lat1, lat8;
      bit sd;
      logic [17:0] m;

      rst_n = 0; start = 0; a = '0; b = '0; cin = 0; sub = 0;
      start8 = 0; a8 = '0; b8 = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_carry_ovf", 32'({carry, ovf}), 32'd0);
      rst_n = 1;
      @(negedge clk);

      m = model_op(16, 64'h7FFF, 64'h0000, 1'b1, 1'b0);
      check("model_pin_ovf", 32'(m), 32'h28000);
      m = model_op(16, 64'h0005, 64'h0007, 1'b1, 1'b1);
      check("model_pin_sub", 32'(m), 32'h0FFFE);

      expect_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, -1, 16'h5555, 1'b0, 1'b0);
      expect_op("addwrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, -1, 16'h0000, 1'b1, 1'b0);
      expect_op("addovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, -1, 16'h8000, 1'b0, 1'b1);
      expect_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b1, -1, 16'hFFFE, 1'b0, 1'b0);
      expect_op("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, -1, 16'h7FFF, 1'b1, 1'b1);
      expect_op("ignstart", 16'h00FF, 16'h0001, 1'b0, 1'b0, 2, 16'h0100, 1'b0, 1'b0);

      run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, -1, 2, lat, bc, sd);
      check("midrst_no_done", 32'(sd), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_sum", 32'(sum), 32'd0);

      expect_op("fresh", 16'h1111, 16'h2222, 1'b0, 1'b0, -1, 16'h3333, 1'b0, 1'b0);
      expect_op("b2b", 16'h0001, 16'h0002, 1'b0, 1'b0, -1, 16'h0003, 1'b0, 1'b0);

      a8 = 8'hFF; b8 = 8'h01; start8 = 1;
      @(negedge clk);
      start8 = 0; cyc = 0; lat1 = -1; lat8 = -1;
      m = model_op(8, 64'hFF, 64'h01, 1'b0, 1'b0);
      while (cyc <= 20 && (lat1 < 0 || lat8 < 0)) begin
         if (done1 && lat1 < 0) begin
            lat1 = cyc;
            check("d1_sum", 32'(sum1), 32'h00);
            check("d1_carry", 32'(c1), 32'd1);
            check("d1_model", 32'({v1, c1, sum1}), 32'({m[17:16], m[7:0]}));
            check("d1_busy", 32'(busy1), 32'd0);
         end
         if (done8 && lat8 < 0) begin
            lat8 = cyc;
            check("d8_sum", 32'(sum8), 32'h00);
            check("d8_carry", 32'(c8), 32'd1);
            check("d8_model", 32'({v8, c8, sum8}), 32'({m[17:16], m[7:0]}));
            check("d8_busy", 32'(busy8), 32'd0);
         end
         @(negedge clk);
         cyc++;
      end
      check("d1_latency", 32'(lat1), 32'd8);
      check("d8_latency", 32'(lat8), 32'd1);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
